// File: rtl/bnn_defs.sv
// Shared definitions for the binary conv pipeline: window FSM states,
// default geometry and the flat window bit-index helper.
package bnn_defs;

    localparam int DEF_K  = 4;
    localparam int DEF_DW = 1;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        EMIT  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } win_state_t;

    // Bit offset of pixel (r,c) inside a flattened KxK window; r=0 is the top row.
    function automatic int win_idx(input int r, input int c, input int k, input int dw);
        return (r * k + c) * dw;
    endfunction

endpackage

// File: rtl/win_row_buffer.sv
// Holds the last K image rows. Rows are written by index while filling and
// shifted upward (oldest row dropped) once the buffer is full. A KxK window
// starting at column col is extracted combinationally.
module win_row_buffer
    import bnn_defs::*;
#(
    parameter int DW    = DEF_DW,
    parameter int K     = DEF_K,
    parameter int IMG_W = 12,
    parameter int IW    = 2,
    parameter int CW    = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                load_en,
    input  logic [IW-1:0]       load_idx,
    input  logic                shift_en,
    input  logic [IMG_W*DW-1:0] row_in,
    input  logic [CW-1:0]       col,
    output logic [K*K*DW-1:0]   win
);

    logic [IMG_W*DW-1:0] rows [K];

    // Row storage: indexed load during fill, upward shift with new bottom row otherwise.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < K; i++) begin
                rows[i] <= '0;
            end
        end else if (shift_en) begin
            for (int i = 0; i < K - 1; i++) begin
                rows[i] <= rows[i + 1];
            end
            rows[K - 1] <= row_in;
        end else if (load_en) begin
            rows[load_idx] <= row_in;
        end
    end

    // KxK extractor; shifts keep every select a constant-width operation.
    always_comb begin
        win = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                win = win | ((K*K*DW)'(DW'(rows[r] >> ((int'(col) + c) * DW))) << win_idx(r, c, K, DW));
            end
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// Sliding-window generator: takes a binary frame one row per beat and emits
// every KxK window (stride 1, no padding) in row-major order.
//
//  state | meaning
//  FILL  | accepting the first K rows of a frame into the row buffer
//  EMIT  | presenting windows of the current row strip, col advancing
//  SHIFT | accepting the next row, which drops the oldest buffered row
//  DONE  | one-cycle frame_done pulse, counters cleared
module conv_window_gen
    import bnn_defs::*;
#(
    parameter int DW    = DEF_DW,
    parameter int K     = DEF_K,
    parameter int IMG_W = 12,
    parameter int IMG_H = 12
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                pix_valid,
    output logic                pix_ready,
    input  logic [IMG_W*DW-1:0] pix_row,
    output logic                conv_valid,
    input  logic                conv_ready,
    output logic [K*K*DW-1:0]   conv_data_in,
    output logic                win_last,
    output logic                frame_done
);

    localparam int CW = (IMG_W - K + 1 > 1) ? $clog2(IMG_W - K + 1) : 1;
    localparam int RW = (IMG_H - K + 1 > 1) ? $clog2(IMG_H - K + 1) : 1;
    localparam int IW = (K > 1) ? $clog2(K) : 1;

    localparam logic [CW-1:0] LAST_COL   = CW'(IMG_W - K);
    localparam logic [RW-1:0] LAST_ROW   = RW'(IMG_H - K);
    localparam logic [IW-1:0] FILL_LAST  = IW'(K - 1);
    localparam bit            ONE_COL    = (IMG_W == K);
    localparam bit            SINGLE_WIN = (IMG_W == K) && (IMG_H == K);

    win_state_t    state;
    logic [IW-1:0] fill_cnt;
    logic [CW-1:0] col;
    logic [RW-1:0] out_row;
    logic          row_acc;
    logic          win_acc;

    assign row_acc = pix_valid && pix_ready;
    assign win_acc = conv_valid && conv_ready;

    win_row_buffer #(
        .DW    (DW),
        .K     (K),
        .IMG_W (IMG_W),
        .IW    (IW),
        .CW    (CW)
    ) u_buf (
        .clk      (clk),
        .rstn     (rstn),
        .load_en  (row_acc && (state == FILL)),
        .load_idx (fill_cnt),
        .shift_en (row_acc && (state == SHIFT)),
        .row_in   (pix_row),
        .col      (col),
        .win      (conv_data_in)
    );

    // Frame sequencing; all handshake outputs are registered so conv_valid never sees conv_ready.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= FILL;
            fill_cnt   <= '0;
            col        <= '0;
            out_row    <= '0;
            pix_ready  <= 1'b1;
            conv_valid <= 1'b0;
            win_last   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (row_acc) begin
                        if (fill_cnt == FILL_LAST) begin
                            state      <= EMIT;
                            fill_cnt   <= '0;
                            col        <= '0;
                            pix_ready  <= 1'b0;
                            conv_valid <= 1'b1;
                            win_last   <= SINGLE_WIN;
                        end else begin
                            fill_cnt <= fill_cnt + IW'(1);
                        end
                    end
                end
                EMIT: begin
                    if (win_acc) begin
                        if (col == LAST_COL) begin
                            conv_valid <= 1'b0;
                            win_last   <= 1'b0;
                            if (out_row < LAST_ROW) begin
                                state     <= SHIFT;
                                pix_ready <= 1'b1;
                            end else begin
                                state      <= DONE;
                                frame_done <= 1'b1;
                            end
                        end else begin
                            col      <= col + CW'(1);
                            win_last <= (out_row == LAST_ROW) && (col + CW'(1) == LAST_COL);
                        end
                    end
                end
                SHIFT: begin
                    if (row_acc) begin
                        state      <= EMIT;
                        out_row    <= out_row + RW'(1);
                        col        <= '0;
                        pix_ready  <= 1'b0;
                        conv_valid <= 1'b1;
                        win_last   <= (out_row + RW'(1) == LAST_ROW) && ONE_COL;
                    end
                end
                DONE: begin
                    state      <= FILL;
                    frame_done <= 1'b0;
                    fill_cnt   <= '0;
                    col        <= '0;
                    out_row    <= '0;
                    pix_ready  <= 1'b1;
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: a pixel-array model produces the expected window
// stream and handshake behaviour; a negedge monitor compares every cycle.
module tb_conv_window_gen;
    import bnn_defs::*;

    localparam int DW    = 1;
    localparam int K     = 4;
    localparam int IMG_W = 12;
    localparam int IMG_H = 12;
    localparam int NWC   = IMG_W - K + 1;
    localparam int NWR   = IMG_H - K + 1;
    localparam int NW    = NWC * NWR;
    localparam int WW    = K * K * DW;

    logic                clk = 1'b0;
    logic                rstn = 1'b1;
    logic                pix_valid = 1'b0;
    logic                pix_ready;
    logic [IMG_W*DW-1:0] pix_row = '0;
    logic                conv_valid;
    logic                conv_ready = 1'b1;
    logic [WW-1:0]       conv_data_in;
    logic                win_last;
    logic                frame_done;

    conv_window_gen #(.DW(DW), .K(K), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .pix_row      (pix_row),
        .conv_valid   (conv_valid),
        .conv_ready   (conv_ready),
        .conv_data_in (conv_data_in),
        .win_last     (win_last),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] pixv [IMG_H][IMG_W];
    logic [WW-1:0] exp_q [$];
    logic [WW-1:0] got_win [NW];

    int rows_acc       = 0;
    int delivered      = 0;
    int frames_done    = 0;
    int last_frame_cnt = 0;
    int stall_cycles   = 0;
    bit fd_pending     = 1'b0;
    int stall_win      = -1;
    int stall_left     = 0;
    bit rand_ready     = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [DW-1:0] gen_pix(input int mode, input int r, input int c);
        case (mode)
            0:       return DW'((r + c) & 1);
            1:       return DW'(r == c);
            2:       return '1;
            3:       return '0;
            default: return DW'($urandom);
        endcase
    endfunction

    function automatic void fill_pix(input int mode);
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
                pixv[r][c] = gen_pix(mode, r, c);
    endfunction

    function automatic logic [WW-1:0] model_win(input int wr, input int wc);
        logic [WW-1:0] w = '0;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                w = w | (WW'(pixv[wr + r][wc + c]) << ((r * K + c) * DW));
        return w;
    endfunction

    function automatic logic [IMG_W*DW-1:0] pack_row(input int r);
        logic [IMG_W*DW-1:0] v = '0;
        for (int c = 0; c < IMG_W; c++)
            v = v | ((IMG_W*DW)'(pixv[r][c]) << (c * DW));
        return v;
    endfunction

    // Per-cycle comparison against the frame-level model.
    always @(negedge clk) begin : monitor
        bit ev;
        bit er;
        if (!rstn) begin
            chk("rst_conv_valid", 64'(conv_valid), 64'(0));
            chk("rst_pix_ready", 64'(pix_ready), 64'(1));
            chk("rst_frame_done", 64'(frame_done), 64'(0));
            chk("rst_win_last", 64'(win_last), 64'(0));
            chk("rst_data", 64'(conv_data_in), 64'(0));
            rows_acc   = 0;
            delivered  = 0;
            fd_pending = 1'b0;
            exp_q.delete();
        end else begin
            ev = (rows_acc >= K) && (delivered < (rows_acc - K + 1) * NWC);
            er = !fd_pending && !ev && (rows_acc < IMG_H);
            chk("conv_valid", 64'(conv_valid), 64'(ev));
            chk("pix_ready", 64'(pix_ready), 64'(er));
            chk("frame_done", 64'(frame_done), 64'(fd_pending));
            if (fd_pending) begin
                frames_done++;
                last_frame_cnt = delivered;
                fd_pending = 1'b0;
                rows_acc   = 0;
                delivered  = 0;
            end else begin
                if (conv_valid) begin
                    if (exp_q.size() == 0) chk("window_unexpected", 64'(1), 64'(0));
                    else chk("window_data", 64'(conv_data_in), 64'(exp_q[0]));
                    chk("win_last", 64'(win_last), 64'(delivered == NW - 1));
                    if (!conv_ready) stall_cycles++;
                end else begin
                    chk("win_last_idle", 64'(win_last), 64'(0));
                end
                if (conv_valid && conv_ready) begin
                    if (delivered < NW) got_win[delivered] = conv_data_in;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    delivered++;
                    if (delivered == NW) fd_pending = 1'b1;
                end
                if (pix_valid && pix_ready) rows_acc++;
            end
        end
    end

    // Downstream ready: a directed stall on one window, otherwise random or always ready.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (stall_left > 0 && conv_valid && delivered == stall_win) begin
                conv_ready = 1'b0;
                stall_left--;
            end else begin
                conv_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    end

    task automatic send_frame(input int mode, input bit gap, input int abort_at, output bit aborted);
        int gcnt = 0;
        aborted = 1'b0;
        fill_pix(mode);
        for (int wr = 0; wr < NWR; wr++)
            for (int wc = 0; wc < NWC; wc++)
                exp_q.push_back(model_win(wr, wc));
        for (int r = 0; r < IMG_H && !aborted; r++) begin
            bit acc = 1'b0;
            int cyc = 0;
            while (!acc && !aborted) begin
                if (abort_at >= 0 && conv_valid && delivered == abort_at) begin
                    pix_valid = 1'b0;
                    rstn = 1'b0;
                    #1;
                    chk("abort_conv_valid", 64'(conv_valid), 64'(0));
                    chk("abort_pix_ready", 64'(pix_ready), 64'(1));
                    chk("abort_data", 64'(conv_data_in), 64'(0));
                    repeat (2) @(posedge clk);
                    #1;
                    rstn = 1'b1;
                    aborted = 1'b1;
                end else begin
                    pix_row   = pack_row(r);
                    pix_valid = gap ? (gcnt % 3 == 0) : 1'b1;
                    gcnt++;
                    @(negedge clk);
                    #1;
                    if (pix_valid && pix_ready) acc = 1'b1;
                    @(posedge clk);
                    #1;
                    cyc++;
                    if (cyc > 600) begin
                        chk("row_accept_timeout", 64'(0), 64'(1));
                        aborted = 1'b1;
                    end
                end
            end
        end
        pix_valid = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        int cyc = 0;
        while (frames_done < target && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("frame_wait", 64'(frames_done >= target), 64'(1));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit ab;
        int n;
        int s;
        #1 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_conv_valid", 64'(conv_valid), 64'(0));
        chk("reset_pix_ready", 64'(pix_ready), 64'(1));
        chk("reset_frame_done", 64'(frame_done), 64'(0));
        chk("reset_data", 64'(conv_data_in), 64'(0));
        rstn = 1'b1;

        fill_pix(0);
        chk("model_cb_00", 64'(model_win(0, 0)), 64'h5A5A);
        chk("model_cb_01", 64'(model_win(0, 1)), 64'hA5A5);
        fill_pix(1);
        chk("model_diag_00", 64'(model_win(0, 0)), 64'h8421);
        chk("model_diag_11", 64'(model_win(1, 1)), 64'h8421);
        chk("model_diag_08", 64'(model_win(0, 8)), 64'h0000);

        n = frames_done;
        send_frame(0, 1'b0, -1, ab);
        wait_frames(n + 1);
        chk("s1_count", 64'(last_frame_cnt), 64'(81));
        chk("s1_w0", 64'(got_win[0]), 64'h5A5A);
        chk("s1_w1", 64'(got_win[1]), 64'hA5A5);
        chk("s1_w80", 64'(got_win[80]), 64'h5A5A);

        n = frames_done;
        send_frame(1, 1'b0, -1, ab);
        wait_frames(n + 1);
        chk("s2_w00", 64'(got_win[0]), 64'h8421);
        chk("s2_w11", 64'(got_win[10]), 64'h8421);
        chk("s2_w08", 64'(got_win[8]), 64'h0000);

        n = frames_done;
        s = stall_cycles;
        stall_win  = 4;
        stall_left = 3;
        send_frame(0, 1'b0, -1, ab);
        wait_frames(n + 1);
        chk("s3_stall_cycles", 64'(stall_cycles - s), 64'(3));
        chk("s3_count", 64'(last_frame_cnt), 64'(81));
        stall_win = -1;

        n = frames_done;
        send_frame(0, 1'b1, -1, ab);
        wait_frames(n + 1);
        chk("s4_count", 64'(last_frame_cnt), 64'(81));
        chk("s4_w0", 64'(got_win[0]), 64'h5A5A);
        chk("s4_w1", 64'(got_win[1]), 64'hA5A5);

        send_frame(0, 1'b0, 39, ab);
        chk("s5_aborted", 64'(ab), 64'(1));
        n = frames_done;
        send_frame(0, 1'b0, -1, ab);
        wait_frames(n + 1);
        chk("s5_count", 64'(last_frame_cnt), 64'(81));

        n = frames_done;
        send_frame(2, 1'b0, -1, ab);
        send_frame(3, 1'b0, -1, ab);
        wait_frames(n + 2);
        chk("s6_w0", 64'(got_win[0]), 64'h0000);
        chk("s6_w80", 64'(got_win[80]), 64'h0000);

        rand_ready = 1'b1;
        n = frames_done;
        send_frame(4, 1'($urandom_range(0, 1)), -1, ab);
        send_frame(4, 1'($urandom_range(0, 1)), -1, ab);
        wait_frames(n + 2);
        chk("s7_count", 64'(last_frame_cnt), 64'(81));
        rand_ready = 1'b0;

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
